// File: rtl/fifo_wc.sv
// Width-converting first-word-fall-through FIFO: DATA_WIDTH-bit words in, RATIO slices out.
// Define FIFO_WC_ERR_EN to add sticky overflow/underflow outputs.
module fifo_wc #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int LSB_FIRST  = 1,
    parameter int AF_MARGIN  = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr,
    input  logic [DATA_WIDTH-1:0]             w_data,
    output logic                              full,
    output logic                              almost_full,
    input  logic                              rd,
    output logic [DATA_WIDTH/RATIO-1:0]       r_data,
    output logic                              empty,
    output logic [ADDR_WIDTH+$clog2(RATIO):0] level
`ifdef FIFO_WC_ERR_EN
    ,
    output logic                              overflow,
    output logic                              underflow
`endif
);

    localparam int S           = DATA_WIDTH / RATIO;
    localparam int SW          = $clog2(RATIO);
    localparam int DEPTH       = 2 ** ADDR_WIDTH;
    localparam int RPW         = ADDR_WIDTH + SW;
    localparam int LW          = RPW + 1;
    localparam int FULL_THRESH = DEPTH * RATIO - RATIO;
    localparam int AF_THRESH   = (DEPTH - 1 - AF_MARGIN) * RATIO;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [RPW-1:0]        r_ptr;
    logic [ADDR_WIDTH-1:0] r_word;
    int                    slice_sel;
    logic                  wr_en;
    logic                  rd_en;
    logic [LW-1:0]         level_next;

    assign wr_en = wr & ~full;
    assign rd_en = rd & ~empty;

    // Upper read-pointer bits pick the word, lower bits pick the slice within it.
    if (SW == 0) begin : g_plain
        assign r_word    = r_ptr;
        assign slice_sel = 0;
    end else begin : g_sliced
        assign r_word    = r_ptr[RPW-1:SW];
        assign slice_sel = (LSB_FIRST != 0) ? int'(r_ptr[SW-1:0])
                                            : RATIO - 1 - int'(r_ptr[SW-1:0]);
    end

    assign r_data = S'(mem[r_word] >> (slice_sel * S));

    always_comb begin
        level_next = level + (wr_en ? LW'(RATIO) : LW'(0)) - LW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_ptr] <= w_data;
        end
    end

    // A word's slot is only released once its last slice is read, so level alone sizes the flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (wr_en) begin
                w_ptr <= w_ptr + ADDR_WIDTH'(1);
            end
            if (rd_en) begin
                r_ptr <= r_ptr + RPW'(1);
            end
            level       <= level_next;
            empty       <= (level_next == '0);
            full        <= (int'(level_next) > FULL_THRESH);
            almost_full <= (int'(level_next) > AF_THRESH);
        end
    end

`ifdef FIFO_WC_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (wr & full);
            underflow <= underflow | (rd & empty);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wc.sv
// Bench for fifo_wc: directed vector table, corner-case sequences and randomized traffic
// checked against a slice-queue model. Checks overflow/underflow when FIFO_WC_ERR_EN is defined.
module tb_fifo_wc;

    localparam int RATIO = 2;
    localparam int SLOTS = 8;
    localparam int FULL_T = SLOTS - RATIO;
    localparam int AF_T = (4 - 1 - 1) * RATIO;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr, rd;
    logic [7:0] w_data;
    logic       full, almost_full, empty;
    logic [3:0] r_data;
    logic [3:0] level;
`ifdef FIFO_WC_ERR_EN
    logic       overflow, underflow;
`endif

    logic        wr4, rd4;
    logic [15:0] wd4;
    logic        full4, af4, empty4;
    logic [3:0]  r_data4;
    logic [4:0]  level4;

    int total = 0;
    int bad = 0;

    logic [3:0] mq[$];
    bit         m_ovf, m_unf;

    always #5 clk = ~clk;

    fifo_wc dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .full(full),
        .almost_full(almost_full), .rd(rd), .r_data(r_data), .empty(empty), .level(level)
`ifdef FIFO_WC_ERR_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    fifo_wc #(.DATA_WIDTH(16), .RATIO(4), .ADDR_WIDTH(2), .LSB_FIRST(0), .AF_MARGIN(1)) dut4 (
        .clk(clk), .reset(reset), .wr(wr4), .w_data(wd4), .full(full4),
        .almost_full(af4), .rd(rd4), .r_data(r_data4), .empty(empty4), .level(level4)
`ifdef FIFO_WC_ERR_EN
        , .overflow(), .underflow()
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, then advance the slice-queue model.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rs);
        bit pre_full, pre_empty;
        pre_full  = mq.size() > FULL_T;
        pre_empty = mq.size() == 0;
        wr = w; rd = r; w_data = d; reset = rs;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; reset = 1'b0;
        if (rs) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && pre_full) m_ovf = 1'b1;
            if (r && pre_empty) m_unf = 1'b1;
            if (r && !pre_empty) void'(mq.pop_front());
            if (w && !pre_full)
                for (int k = 0; k < RATIO; k++) mq.push_back(4'((d >> (4 * k)) & 8'h0f));
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"}, int'(level), mq.size());
        check({tag, ".empty"}, int'(empty), int'(mq.size() == 0));
        check({tag, ".full"}, int'(full), int'(mq.size() > FULL_T));
        check({tag, ".almost_full"}, int'(almost_full), int'(mq.size() > AF_T));
        if (mq.size() != 0) check({tag, ".r_data"}, int'(r_data), int'(mq[0]));
`ifdef FIFO_WC_ERR_EN
        check({tag, ".overflow"}, int'(overflow), int'(m_ovf));
        check({tag, ".underflow"}, int'(underflow), int'(m_unf));
`endif
    endtask

    typedef struct {
        bit         w;
        bit         r;
        logic [7:0] d;
        int         lvl;
        bit         f;
        bit         af;
        bit         e;
        logic [3:0] rdat;
    } vec_t;

    vec_t vec[19];

    initial begin
        vec[0]  = '{1, 0, 8'h21, 2, 0, 0, 0, 4'h1};
        vec[1]  = '{1, 0, 8'h43, 4, 0, 0, 0, 4'h1};
        vec[2]  = '{1, 0, 8'h65, 6, 0, 1, 0, 4'h1};
        vec[3]  = '{1, 0, 8'h87, 8, 1, 1, 0, 4'h1};
        vec[4]  = '{1, 0, 8'h55, 8, 1, 1, 0, 4'h1};
        vec[5]  = '{0, 1, 8'h00, 7, 1, 1, 0, 4'h2};
        vec[6]  = '{0, 1, 8'h00, 6, 0, 1, 0, 4'h3};
        vec[7]  = '{1, 0, 8'hA9, 8, 1, 1, 0, 4'h3};
        vec[8]  = '{0, 1, 8'h00, 7, 1, 1, 0, 4'h4};
        vec[9]  = '{0, 1, 8'h00, 6, 0, 1, 0, 4'h5};
        vec[10] = '{0, 1, 8'h00, 5, 0, 1, 0, 4'h6};
        vec[11] = '{0, 1, 8'h00, 4, 0, 0, 0, 4'h7};
        vec[12] = '{0, 1, 8'h00, 3, 0, 0, 0, 4'h8};
        vec[13] = '{0, 1, 8'h00, 2, 0, 0, 0, 4'h9};
        vec[14] = '{0, 1, 8'h00, 1, 0, 0, 0, 4'hA};
        vec[15] = '{0, 1, 8'h00, 0, 0, 0, 1, 4'h0};
        vec[16] = '{1, 1, 8'h3C, 2, 0, 0, 0, 4'hC};
        vec[17] = '{1, 1, 8'h5B, 3, 0, 0, 0, 4'h3};
        vec[18] = '{1, 1, 8'h7E, 4, 0, 0, 0, 4'hB};

        wr = 0; rd = 0; w_data = 0; reset = 1;
        wr4 = 0; rd4 = 0; wd4 = 0;
        m_ovf = 0; m_unf = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        check("reset.level", int'(level), 0);
        check("reset.empty", int'(empty), 1);
        check("reset.full", int'(full), 0);
        check("reset.almost_full", int'(almost_full), 0);
        check_all("reset");

        // Directed table: fill, overfill, partial drain, wrap, drain, empty wr+rd.
        for (int i = 0; i < 19; i++) begin
            step(vec[i].w, vec[i].r, vec[i].d, 1'b0);
            check($sformatf("vec%0d.level", i), int'(level), vec[i].lvl);
            check($sformatf("vec%0d.full", i), int'(full), int'(vec[i].f));
            check($sformatf("vec%0d.almost_full", i), int'(almost_full), int'(vec[i].af));
            check($sformatf("vec%0d.empty", i), int'(empty), int'(vec[i].e));
            if (!vec[i].e) check($sformatf("vec%0d.r_data", i), int'(r_data), int'(vec[i].rdat));
            check_all($sformatf("vec%0d", i));
        end

        // Hold wr and rd together with data present, then drain in order.
        step(0, 0, 8'h00, 1);
        check_all("hold.reset");
        step(1, 0, 8'hF0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 8'(8'h12 * (i + 1)), 0);
            check_all($sformatf("hold%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 8'h00, 0);
            check_all($sformatf("holddrain%0d", i));
        end

        // Reset mid-operation while a write is requested.
        step(1, 0, 8'h12, 0);
        step(1, 0, 8'h34, 0);
        step(1, 0, 8'h56, 0);
        step(0, 1, 8'h00, 0);
        check("midrst.pre_level", int'(level), 5);
        step(1, 0, 8'hFF, 1);
        check("midrst.level", int'(level), 0);
        check("midrst.empty", int'(empty), 1);
        step(0, 0, 8'h00, 0);
        check("midrst.after_level", int'(level), 0);
        check("midrst.after_empty", int'(empty), 1);
        check_all("midrst");

        // MSB-first, 4:1 instance.
        wr4 = 1; wd4 = 16'h1234;
        @(posedge clk);
        #1;
        wr4 = 0;
        check("r4.level", int'(level4), 4);
        check("r4.empty", int'(empty4), 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("r4.slice%0d", i), int'(r_data4), i + 1);
            rd4 = 1;
            @(posedge clk);
            #1;
            rd4 = 0;
        end
        check("r4.level_end", int'(level4), 0);
        check("r4.empty_end", int'(empty4), 1);

        // Randomized traffic against the slice-queue model.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                 8'($urandom), ($urandom_range(0, 199) == 0));
            check_all($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
